// File: rtl/mips32_fetch_unit.sv
// MIPS32 instruction-fetch front end: fetches words from a variable-latency
// instruction memory (req/ack), buffers {ir, npc} in a prefetch FIFO and hands
// them to ID over valid/ready. Supports branch redirect with squash of the
// in-flight fetch, and stops fetching once an HLT word has been fetched.
module mips32_fetch_unit #(
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned AW       = 10,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic          clk1,
  input  logic          rst_n,
  output logic          imem_req,
  output logic [AW-1:0] imem_addr,
  input  logic          imem_ack,
  input  logic [31:0]   imem_rdata,
  input  logic          redirect,
  input  logic [31:0]   redirect_pc,
  output logic          ifid_valid,
  output logic [31:0]   ifid_ir,
  output logic [31:0]   ifid_npc,
  input  logic          ifid_ready,
  output logic          halted
);

  localparam int unsigned PW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW     = PW + 1;
  localparam logic [5:0]  OP_HLT = 6'b111111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_HALT = 2'd2
  } state_e;

  state_e          state_q;
  logic [31:0]     fetch_pc_q;
  logic            squash_q;
  logic            req_q;
  logic [AW-1:0]   addr_q;
  logic            halted_q;
  logic [31:0]     ir_mem_q  [DEPTH];
  logic [31:0]     npc_mem_q [DEPTH];
  logic [PW-1:0]   rd_ptr_q;
  logic [PW-1:0]   wr_ptr_q;
  logic [CW-1:0]   count_q;

  logic            ack_c;
  logic            pop_c;
  logic            push_c;
  logic            is_hlt_c;
  logic [CW-1:0]   count_nx_c;
  logic [31:0]     pc_inc_c;

  // Handshake qualifiers; redirect overrides both FIFO push and pop.
  assign ack_c      = req_q & imem_ack;
  assign pop_c      = (count_q != '0) & ifid_ready & ~redirect;
  assign push_c     = (state_q == S_BUSY) & ack_c & ~squash_q & ~redirect;
  assign count_nx_c = count_q + CW'(push_c) - CW'(pop_c);
  assign pc_inc_c   = fetch_pc_q + 32'd1;
  assign is_hlt_c   = (imem_rdata[31:26] == OP_HLT);

  assign imem_req   = req_q;
  assign imem_addr  = addr_q;
  assign ifid_valid = (count_q != '0);
  assign ifid_ir    = ir_mem_q[rd_ptr_q];
  assign ifid_npc   = npc_mem_q[rd_ptr_q];
  assign halted     = halted_q;

  // Fetch FSM, prefetch FIFO and request outputs.
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      fetch_pc_q <= RESET_PC;
      squash_q   <= 1'b0;
      req_q      <= 1'b0;
      addr_q     <= RESET_PC[AW-1:0];
      halted_q   <= 1'b0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        ir_mem_q[i]  <= 32'h0;
        npc_mem_q[i] <= 32'h0;
      end
    end else if (redirect) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      fetch_pc_q <= redirect_pc;
      halted_q   <= 1'b0;
      if (state_q == S_BUSY && !ack_c) begin
        // Request is in flight: keep it on the bus, drop its response later.
        squash_q <= 1'b1;
      end else if (state_q == S_BUSY) begin
        // Response arrives now and is dropped; refetch immediately.
        squash_q <= 1'b0;
        addr_q   <= redirect_pc[AW-1:0];
      end else begin
        state_q  <= S_IDLE;
        req_q    <= 1'b0;
        squash_q <= 1'b0;
      end
    end else begin
      if (pop_c) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
      end
      if (push_c) begin
        ir_mem_q[wr_ptr_q]  <= imem_rdata;
        npc_mem_q[wr_ptr_q] <= pc_inc_c;
        wr_ptr_q            <= wr_ptr_q + PW'(1);
      end
      count_q <= count_nx_c;
      case (state_q)
        S_IDLE: begin
          if (count_q < CW'(DEPTH)) begin
            state_q <= S_BUSY;
            req_q   <= 1'b1;
            addr_q  <= fetch_pc_q[AW-1:0];
          end
        end
        S_BUSY: begin
          if (ack_c) begin
            if (squash_q) begin
              squash_q <= 1'b0;
              addr_q   <= fetch_pc_q[AW-1:0];
            end else begin
              fetch_pc_q <= pc_inc_c;
              if (is_hlt_c) begin
                state_q  <= S_HALT;
                req_q    <= 1'b0;
                halted_q <= 1'b1;
              end else if (count_nx_c < CW'(DEPTH)) begin
                addr_q <= pc_inc_c[AW-1:0];
              end else begin
                state_q <= S_IDLE;
                req_q   <= 1'b0;
              end
            end
          end
        end
        S_HALT: begin
          req_q <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          req_q   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mips32_fetch_unit.sv
// Randomized self-checking bench for mips32_fetch_unit. The reference model
// tracks the program-order PC that ID must see next and the address the next
// fresh fetch request must carry after a redirect.
module tb_mips32_fetch_unit;

  localparam int unsigned DEPTH    = 4;
  localparam int unsigned AW       = 10;
  localparam logic [31:0] RESET_PC = 32'h0;

  logic          clk1 = 1'b0;
  logic          rst_n;
  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic          imem_ack;
  logic [31:0]   imem_rdata;
  logic          redirect;
  logic [31:0]   redirect_pc;
  logic          ifid_valid;
  logic [31:0]   ifid_ir;
  logic [31:0]   ifid_npc;
  logic          ifid_ready;
  logic          halted;

  mips32_fetch_unit #(.DEPTH(DEPTH), .AW(AW), .RESET_PC(RESET_PC)) dut (
    .clk1        (clk1),
    .rst_n       (rst_n),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .ifid_valid  (ifid_valid),
    .ifid_ir     (ifid_ir),
    .ifid_npc    (ifid_npc),
    .ifid_ready  (ifid_ready),
    .halted      (halted)
  );

  always #5 clk1 = ~clk1;

  int n_checks = 0;
  int n_pass   = 0;

  // stimulus knobs
  int unsigned   lat_lo, lat_hi, ready_pct, redir_pct;
  bit            hlt_en;
  logic [AW-1:0] hlt_addr = AW'(5);
  bit            force_redir;
  logic [31:0]   force_target;
  bit            redir_on_ack;
  logic [31:0]   redir_on_ack_target;
  bit            capture_fresh;
  logic [AW-1:0] captured_addr;

  // memory responder state
  int unsigned   wcnt, lat_cur;
  bit            prev_req, prev_ack;
  logic [AW-1:0] prev_addr;
  int            acks_total;

  // reference model state
  logic [31:0]   exp_pc;
  bit            exp_stopped;
  bit            redir_pend;
  logic [AW-1:0] redir_tgt;
  int            n_deliv;
  bit            want_first;
  logic [31:0]   first_ir, first_npc, last_ir;

  function automatic logic [31:0] mem_word(input logic [AW-1:0] a);
    if (hlt_en && a == hlt_addr) return 32'hFC00_0000;
    return 32'h1000_0000 + 32'(a);
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic set_knobs(input int unsigned llo, input int unsigned lhi,
                           input int unsigned rdy, input int unsigned rdr, input bit he);
    lat_lo = llo; lat_hi = lhi; ready_pct = rdy; redir_pct = rdr; hlt_en = he;
  endtask

  task automatic model_reset();
    exp_pc = RESET_PC; exp_stopped = 0; redir_pend = 0; want_first = 0;
    wcnt = 0; lat_cur = $urandom_range(lat_hi, lat_lo);
    prev_req = 0; prev_ack = 0; prev_addr = '0; acks_total = 0;
    force_redir = 0; redir_on_ack = 0; capture_fresh = 0;
  endtask

  task automatic do_reset();
    @(negedge clk1);
    rst_n = 1'b0; imem_ack = 1'b0; redirect = 1'b0; ifid_ready = 1'b0;
    model_reset();
    #1;
    check("rst_req",    32'(imem_req),   32'h0);
    check("rst_valid",  32'(ifid_valid), 32'h0);
    check("rst_ir",     ifid_ir,         32'h0);
    check("rst_npc",    ifid_npc,        32'h0);
    check("rst_halted", 32'(halted),     32'h0);
    repeat (2) @(negedge clk1);
    rst_n = 1'b1;
  endtask

  // One clock of stimulus plus model update, evaluated at the falling edge.
  task automatic step();
    logic        fresh;
    logic [31:0] w;
    @(negedge clk1);
    imem_ack = 1'b0;
    if (imem_req) begin
      if (wcnt >= lat_cur) begin
        imem_ack   = 1'b1;
        imem_rdata = mem_word(imem_addr);
        wcnt       = 0;
        lat_cur    = $urandom_range(lat_hi, lat_lo);
        acks_total++;
      end else begin
        imem_rdata = $urandom;
        wcnt++;
      end
    end else begin
      wcnt = 0;
    end
    ifid_ready = ($urandom_range(99, 0) < ready_pct);
    redirect   = 1'b0;
    if (force_redir) begin
      redirect = 1'b1; redirect_pc = force_target; force_redir = 0;
    end else if (redir_on_ack && imem_ack) begin
      redirect = 1'b1; redirect_pc = redir_on_ack_target; ifid_ready = 1'b1; redir_on_ack = 0;
    end else if ($urandom_range(99, 0) < redir_pct) begin
      redirect    = 1'b1;
      redirect_pc = ($urandom_range(9, 0) == 0) ? 32'hFFFF_FFFE : 32'($urandom_range(63, 0));
    end

    // request-side rules
    fresh = imem_req && (!prev_req || prev_ack);
    if (imem_req && !fresh) check("addr_hold", 32'(imem_addr), 32'(prev_addr));
    if (halted) check("halt_noreq", 32'(imem_req), 32'h0);
    if (fresh && redir_pend) begin
      check("redir_addr", 32'(imem_addr), 32'(redir_tgt));
      redir_pend = 0;
    end
    if (fresh && capture_fresh) begin
      captured_addr = imem_addr; capture_fresh = 0;
    end
    prev_req = imem_req; prev_ack = imem_ack; prev_addr = imem_addr;

    // delivery to ID in program order
    if (redirect) begin
      exp_pc = redirect_pc; exp_stopped = 0; redir_pend = 1;
      redir_tgt = redirect_pc[AW-1:0]; want_first = 1;
    end else if (exp_stopped) begin
      check("empty_after_hlt", 32'(ifid_valid), 32'h0);
    end else if (ifid_valid && ifid_ready) begin
      w = mem_word(exp_pc[AW-1:0]);
      check("ir",  ifid_ir,  w);
      check("npc", ifid_npc, exp_pc + 32'd1);
      if (want_first) begin
        first_ir = ifid_ir; first_npc = ifid_npc; want_first = 0;
      end
      last_ir = ifid_ir;
      if (w[31:26] == 6'b111111) begin
        check("halted_at_hlt", 32'(halted), 32'h1);
        exp_stopped = 1;
      end
      exp_pc = exp_pc + 32'd1;
      n_deliv++;
    end
  endtask

  task automatic run_deliv(input int n, input int budget, input string tag);
    int start = n_deliv;
    int k = 0;
    while ((n_deliv - start) < n && k < budget) begin
      step();
      k++;
    end
    check({tag, "_done"}, 32'((n_deliv - start) >= n), 32'h1);
  endtask

  initial begin
    int k;
    int start;
    rst_n = 1'b0; imem_ack = 1'b0; imem_rdata = '0; redirect = 1'b0;
    redirect_pc = '0; ifid_ready = 1'b0; captured_addr = '1;
    first_ir = '0; first_npc = '0; last_ir = '0;
    set_knobs(0, 0, 100, 0, 0);

    // 1: zero-wait streaming
    do_reset();
    step();
    check("t1_v0",  32'(ifid_valid), 32'h0);
    check("t1_req", 32'(imem_req),   32'h1);
    step();
    check("t1_v1",  32'(ifid_valid), 32'h1);
    for (int i = 0; i < 10; i++) begin
      step();
      check("t1_nobubble", 32'(ifid_valid), 32'h1);
    end

    // 2: back-pressure fills the FIFO, then drains and resumes
    set_knobs(0, 0, 0, 0, 0);
    do_reset();
    repeat (10) step();
    check("t2_acks",  32'(acks_total), 32'd4);
    check("t2_req",   32'(imem_req),   32'h0);
    check("t2_valid", 32'(ifid_valid), 32'h1);
    check("t2_ir",    ifid_ir,         32'h1000_0000);
    ready_pct = 100; capture_fresh = 1;
    run_deliv(8, 40, "t2");
    check("t2_resume", 32'(captured_addr), 32'd4);

    // 3: redirect while address 2 is pending (latency 3)
    set_knobs(3, 3, 100, 0, 0);
    do_reset();
    k = 0;
    while (!(imem_req && imem_addr == AW'(2)) && k < 40) begin step(); k++; end
    check("t3_seen_addr2", 32'(imem_req && imem_addr == AW'(2)), 32'h1);
    force_redir = 1; force_target = 32'h20;
    step();
    run_deliv(4, 80, "t3");
    check("t3_first_ir",  first_ir,  32'h1000_0020);
    check("t3_first_npc", first_npc, 32'h21);

    // 4: HLT at address 5, then redirect out of halt
    set_knobs(0, 2, 100, 0, 1);
    do_reset();
    k = 0;
    while (!halted && k < 100) begin step(); k++; end
    check("t4_halted", 32'(halted), 32'h1);
    repeat (8) step();
    check("t4_hlt_ir", last_ir, 32'hFC00_0000);
    check("t4_drained", 32'(ifid_valid), 32'h0);
    force_redir = 1; force_target = 32'h10;
    step();
    step();
    check("t4_unhalt", 32'(halted), 32'h0);
    run_deliv(4, 60, "t4");
    check("t4_first_ir", first_ir, 32'h1000_0010);

    // 5a: redirect coincident with ack and pop
    set_knobs(2, 2, 0, 0, 0);
    do_reset();
    k = 0;
    while (acks_total < 3 && k < 40) begin step(); k++; end
    redir_on_ack = 1; redir_on_ack_target = 32'h30;
    k = 0;
    while (redir_on_ack && k < 10) begin step(); k++; end
    step();
    check("t5_flush", 32'(ifid_valid), 32'h0);
    check("t5_addr",  32'(imem_addr),  32'h30);
    ready_pct = 100;
    run_deliv(3, 40, "t5");
    check("t5_first_ir", first_ir, 32'h1000_0030);

    // 5b: redirect with pop on a full FIFO
    set_knobs(0, 0, 0, 0, 0);
    do_reset();
    repeat (8) step();
    check("t5b_acks", 32'(acks_total), 32'd4);
    ready_pct = 100; force_redir = 1; force_target = 32'h3A;
    step();
    ready_pct = 0;
    step();
    check("t5b_flush", 32'(ifid_valid), 32'h0);
    ready_pct = 100;
    run_deliv(3, 40, "t5b");
    check("t5b_first_ir", first_ir, 32'h1000_003A);

    // 6: asynchronous reset while a fetch is outstanding
    set_knobs(3, 3, 0, 0, 0);
    do_reset();
    k = 0;
    while (!(acks_total >= 2 && imem_req && !imem_ack) && k < 40) begin step(); k++; end
    check("t6_pre_valid", 32'(ifid_valid), 32'h1);
    #2;
    rst_n = 1'b0; imem_ack = 1'b0;
    #1;
    check("t6_req",   32'(imem_req),   32'h0);
    check("t6_valid", 32'(ifid_valid), 32'h0);
    model_reset();
    repeat (2) @(negedge clk1);
    rst_n = 1'b1;
    ready_pct = 100; capture_fresh = 1;
    run_deliv(3, 40, "t6");
    check("t6_first_addr", 32'(captured_addr), RESET_PC);

    // random traffic: latency, back-pressure, redirects (incl. wrap), HLT
    set_knobs(0, 3, 70, 4, 1);
    do_reset();
    start = n_deliv;
    repeat (3000) step();
    check("rand_progress", 32'((n_deliv - start) > 100), 32'h1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
